axis_width_downsizer: RTL
=========================

// Module: axis_width_downsizer
// PURPOSE
//   AXI-Stream width down-converter feeding the NoC flit path: accepts one wide beat on s_axis
//   and emits RATIO narrow beats on m_axis, LSB slice first, with TLAST carried through.
//   Sits between the wide AXI-side packetizer and the narrow flit-width axis_if link.
//   Provides a packet counter for the PMU block.
//   Full throughput: one m beat per cycle while m_axis.TREADY is high, no bubbles between input beats.
// PARAMETERS
//   OUT_WIDTH  32  m_axis TDATA width in bits (multiple of 8)
//   RATIO      2   input/output width ratio; elaboration error if RATIO < 2
//   IN_WIDTH   OUT_WIDTH*RATIO (localparam)  s_axis TDATA width
//   CNT_WIDTH  32  width of pkt_count
// PORTS
//   ACLK            in   1          clock; all state changes on rising edge
//   ARESET          in   1          asynchronous, active-high reset
//   s_axis.TVALID   in   1          input beat valid (axis_if.s, DATA_WIDTH=IN_WIDTH)
//   s_axis.TREADY   out  1          input beat accepted
//   s_axis.TDATA    in   IN_WIDTH   wide input data
//   s_axis.TLAST    in   1          last beat of packet
//   m_axis.TVALID   out  1          output flit valid (axis_if.m, DATA_WIDTH=OUT_WIDTH)
//   m_axis.TREADY   in   1          downstream ready
//   m_axis.TDATA    out  OUT_WIDTH  narrow output data
//   m_axis.TLAST    out  1          last flit of packet
//   pkt_count       out  CNT_WIDTH  packets completed on m_axis, wraps at 2^CNT_WIDTH
// BEHAVIOUR
//   Interface requires TLAST_PRESENT defined. TSTRB/TKEEP/TID/TDEST/TUSER are not carried.
//   State: buf_data[IN_WIDTH], buf_last, buf_valid, idx[max(1,$clog2(RATIO))], pkt_count.
//   Reset (async, ARESET=1): buf_valid=0, idx=0, pkt_count=0 -> m_axis.TVALID=0, m_axis.TLAST=0.
//     s_axis.TREADY=1 while reset is held. buf_data is don't-care.
//   Reset mid-packet discards the buffered beat and any unsent slices; no partial flush.
//   Handshakes: s_hs = s.TVALID & s.TREADY; m_hs = m.TVALID & m.TREADY.
//   Combinational outputs:
//     m.TVALID = buf_valid
//     m.TDATA  = buf_data[idx*OUT_WIDTH +: OUT_WIDTH]
//     m.TLAST  = buf_valid & buf_last & (idx == RATIO-1)
//     s.TREADY = ~buf_valid | (m.TREADY & idx == RATIO-1)
//   No combinational s->m path (data); the s.TREADY <- m.TREADY path exists by design.
//   Sequential:
//     m_hs & idx != RATIO-1: idx <= idx+1.
//     m_hs & idx == RATIO-1: idx <= 0; buf_valid <= s_hs.
//     s_hs: buf_data <= s.TDATA; buf_last <= s.TLAST; buf_valid <= 1.
//       Simultaneous final-slice m_hs and s_hs loads the new beat the same cycle (zero bubble).
//     m_hs & m.TLAST: pkt_count <= pkt_count+1 (modulo wrap).
//   Latency: first slice of an accepted beat appears on m_axis the cycle after s_hs.
//   AXIS rules on m_axis:
//     - once TVALID=1, TVALID/TDATA/TLAST hold stable until m_hs;
//     - TVALID never depends on TREADY.
//   s_axis.TVALID without TREADY: the upstream holds; the block does not sample TDATA.
//   A packet of N input beats produces exactly N*RATIO output beats. TLAST is set only on the last.
//   Backpressure: m.TREADY=0 freezes idx, buf and all outputs; s.TREADY=0 while buf_valid=1.
// TESTING
//   1) RATIO=2; s beat 0xAAAA_BBBB_CCCC_DDDD, TLAST=1, m.TREADY=1
//      -> m: 0xCCCC_DDDD (TLAST=0) then 0xAAAA_BBBB (TLAST=1); pkt_count=1.
//   2) Back-to-back 4-beat packet, m.TREADY=1 throughout
//      -> 8 consecutive m beats, no TVALID gaps; s.TREADY high every 2nd cycle; one TLAST.
//   3) m.TREADY random 50% -> output sequence equals scoreboard of sliced inputs;
//      m.TDATA is stable whenever TVALID & ~TREADY.
//   4) ARESET pulsed after the first slice of a beat
//      -> m.TVALID=0 immediately (async); pkt_count=0;
//      the next packet after reset is emitted intact from slice 0.
//   5) RATIO=4, OUT_WIDTH=8, s beat 0x44332211 TLAST=1 -> m: 0x11, 0x22, 0x33, 0x44(TLAST); idx wraps to 0.
//   6) CNT_WIDTH=4, send 17 single-beat packets -> pkt_count reads 1 (wrap).

Source files
------------

// File: rtl/axis_width_downsizer.sv
// axis_width_downsizer
// AXI-Stream width down-converter. It accepts one wide beat on s_axis and
// emits RATIO narrow beats on m_axis, least-significant slice first. TLAST is
// raised only on the final slice of a beat that carried TLAST. pkt_count
// counts packets completed on m_axis and wraps.
module axis_width_downsizer #(
  parameter int OUT_WIDTH = 32,
  parameter int RATIO     = 2,
  parameter int CNT_WIDTH = 32
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic [OUT_WIDTH*RATIO-1:0]   s_axis_tdata,
  input  logic                         s_axis_tlast,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [OUT_WIDTH-1:0]         m_axis_tdata,
  output logic                         m_axis_tlast,
  output logic [CNT_WIDTH-1:0]         pkt_count
);

  localparam int IN_WIDTH = OUT_WIDTH * RATIO;
  localparam int IDX_W    = (RATIO > 2) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  if (RATIO < 2) begin : g_ratio_check
    $error("axis_width_downsizer: RATIO must be at least 2");
  end
  if ((OUT_WIDTH % 8) != 0) begin : g_width_check
    $error("axis_width_downsizer: OUT_WIDTH must be a multiple of 8");
  end

  logic [IN_WIDTH-1:0]  buf_data_q,  buf_data_d;
  logic                 buf_last_q,  buf_last_d;
  logic                 buf_valid_q, buf_valid_d;
  logic [IDX_W-1:0]     idx_q,       idx_d;
  logic [CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;
  logic                 at_last_s;
  logic                 s_hs_s;
  logic                 m_hs_s;

  // Output view of the buffer; s_axis_tready looks through m_axis_tready so
  // the final slice and the next wide beat can swap in the same cycle.
  always_comb begin
    at_last_s     = (idx_q == LAST_IDX);
    m_axis_tvalid = buf_valid_q;
    m_axis_tdata  = buf_data_q[idx_q*OUT_WIDTH +: OUT_WIDTH];
    m_axis_tlast  = buf_valid_q & buf_last_q & at_last_s;
    s_axis_tready = ~buf_valid_q | (m_axis_tready & at_last_s);
    pkt_count     = pkt_count_q;
    s_hs_s        = s_axis_tvalid & s_axis_tready;
    m_hs_s        = m_axis_tvalid & m_axis_tready;
  end

  // Next-state: advance the slice index on each output handshake, reload the
  // buffer on each input handshake, count packets on the final TLAST slice.
  always_comb begin
    buf_data_d  = buf_data_q;
    buf_last_d  = buf_last_q;
    buf_valid_d = buf_valid_q;
    idx_d       = idx_q;
    pkt_count_d = pkt_count_q;

    if (m_hs_s) begin
      if (at_last_s) begin
        idx_d       = '0;
        buf_valid_d = 1'b0;
      end else begin
        idx_d       = idx_q + IDX_W'(1);
        buf_valid_d = buf_valid_q;
      end
    end else begin
      idx_d       = idx_q;
      buf_valid_d = buf_valid_q;
    end

    if (s_hs_s) begin
      buf_data_d  = s_axis_tdata;
      buf_last_d  = s_axis_tlast;
      buf_valid_d = 1'b1;
    end else begin
      buf_data_d  = buf_data_q;
      buf_last_d  = buf_last_q;
    end

    if (m_hs_s && m_axis_tlast) begin
      pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
    end else begin
      pkt_count_d = pkt_count_q;
    end
  end

  // State registers; reset drops any buffered beat and unsent slices.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      buf_data_q  <= '0;
      buf_last_q  <= 1'b0;
      buf_valid_q <= 1'b0;
      idx_q       <= '0;
      pkt_count_q <= '0;
    end else begin
      buf_data_q  <= buf_data_d;
      buf_last_q  <= buf_last_d;
      buf_valid_q <= buf_valid_d;
      idx_q       <= idx_d;
      pkt_count_q <= pkt_count_d;
    end
  end

endmodule
